loop_add_const_pipe: RTL and testbench
======================================

// Module: loop_add_const_pipe
// PURPOSE
//  Parametrised II=1 pipelined loop kernel: mem[DST_BASE+k] = mem[SRC_BASE+k] + addend, k=0..TRIP_COUNT-1.
//  Drives one read port and one write port of a RAM2-style memory.
//  Adds a start/busy/valid handshake, a runtime addend, configurable RAM read latency and re-runs.
//  Successor to the fixed add-4, start-on-reset loop kernels.
// PARAMETERS
//  DATA_W      32  data word width (rdata_0, wdata_0, addend)
//  ADDR_W      5   memory address width
//  TRIP_COUNT  6   loop iterations per run; must be >=1 (elaboration error otherwise)
//  SRC_BASE    10  first read address
//  DST_BASE    0   first write address
//  RD_LAT      1   clock edges from raddr_0 driven to rdata_0 valid; legal values are 0, 1 or 2
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       synchronous, active-high reset
//  start    in   1       run request; sampled on clk edges
//  addend   in   DATA_W  constant added to each element; latched at start accept
//  busy     out  1       run in progress
//  valid    out  1       last run complete; results committed to memory
//  raddr_0  out  ADDR_W  read address (registered)
//  rdata_0  in   DATA_W  read data, valid RD_LAT edges after raddr_0
//  waddr_0  out  ADDR_W  write address (registered)
//  wdata_0  out  DATA_W  write data (registered)
//  wen_0    out  1       write enable; the RAM commits on the edge ending the cycle where wen_0=1
// BEHAVIOUR
//  Reset: rst=1 at an edge forces IDLE. busy=0, valid=0, wen_0=0, raddr_0=0, waddr_0=0, wdata_0=0.
//    All pipeline valid bits are cleared. A reset mid-run aborts the run; the write in flight is dropped.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//    IDLE -start-> RUN; RUN -last issue-> DRAIN; DRAIN -last write commits-> DONE; DONE -start-> RUN.
//  Start accept: start=1 at edge E0 in IDLE or DONE. That edge latches addend, sets busy=1 and clears valid.
//  start is ignored while busy=1 (no queuing).
//  Issue: after edge E(k), raddr_0 = SRC_BASE+k, for k=0..TRIP_COUNT-1. One issue per cycle, no stalls.
//  Data path:
//    - rdata_0 for element k is captured at edge E(k+RD_LAT+1).
//    - The sum is registered into wdata_0 at that same edge.
//    - At that edge waddr_0 = DST_BASE+k and wen_0 = 1.
//  Latency:
//    - First wen_0 is high in the cycle after E(RD_LAT+1).
//    - Last wen_0 is high in the cycle after E(TRIP_COUNT+RD_LAT).
//    - At E(TRIP_COUNT+RD_LAT+1): busy=0, valid=1, wen_0=0.
//  valid holds at 1 until the next start accept or reset. It is never high while busy=1.
//  Arithmetic: wdata_0 = (rdata_0 + addend) mod 2^DATA_W (unsigned wrap).
//  Addresses: addresses wrap mod 2^ADDR_W, e.g. SRC_BASE=30, ADDR_W=5 reads 30,31,0,1,...
//  Hazards:
//    - No forwarding is provided.
//    - In-place operation (SRC_BASE==DST_BASE) is correct, because each address is read before it is written.
//    - Overlap with DST_BASE < SRC_BASE+k and DST_BASE > SRC_BASE is undefined.
//  Simultaneous rst and start at one edge: rst wins and the state is IDLE.
//  Between runs raddr_0 and waddr_0 hold their last values, and wen_0=0.
// CONFIGURATION
//  LOOP_ADD_SAT_EN defined:
//    - Unsigned saturating add: if the true sum exceeds 2^DATA_W-1, wdata_0 = {DATA_W{1'b1}}.
//    - Adds no pipeline stage; latency is unchanged.
//  LOOP_ADD_SAT_EN undefined: wrapping add as specified above.
// TESTING
//  Memory: RAM2 model with RD_LAT=1. Parameter defaults apply unless a test states otherwise.
//  1. Basic run:
//    - Stimulus: preload mem[10]=10, mem[11]=5; addend=4; start pulse at E0.
//    - Required: wen_0 first high after E2. valid=0 after E7, valid=1 after E8. mem[0]=14, mem[1]=9.
//  2. Hold and ignore:
//    - Stimulus: after test 1, run 20 idle cycles; then pulse start while busy during a second run.
//    - Required: valid stays 1 through the idle cycles and mem[0..1] are unchanged.
//    - Required: the busy-time start is ignored, giving exactly TRIP_COUNT writes.
//  3. Re-run:
//    - Stimulus: after valid=1, start with addend=1.
//    - Required: valid drops at the accept edge; mem[0]=11 and mem[1]=6 (source reads 10 and 5).
//  4. Reset mid-run:
//    - Stimulus: assert rst for 1 cycle at E3 of a run.
//    - Required: from that edge, busy=0, valid=0, wen_0=0. No further writes occur. The next start runs cleanly.
//  5. Address wrap:
//    - Stimulus: ADDR_W=5, SRC_BASE=30, DST_BASE=2, TRIP_COUNT=4; mem[30]=1, mem[31]=2, mem[0]=3, mem[1]=4; addend=4.
//    - Required: mem[2..5] = 5, 6, 7, 8.
//  6. Overflow:
//    - Stimulus: mem[10]=32'hFFFF_FFFE, addend=4.
//    - Required: mem[0]=2 without LOOP_ADD_SAT_EN; mem[0]=32'hFFFF_FFFF with it.

Source files
------------

// File: rtl/loop_add_const_pipe.sv
// II=1 loop kernel: mem[DST_BASE+k] = mem[SRC_BASE+k] + addend over one RAM2 read/write port pair.
// Define LOOP_ADD_SAT_EN for an unsigned saturating add instead of the wrapping add.
module loop_add_const_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int TRIP_COUNT = 6,
  parameter int SRC_BASE   = 10,
  parameter int DST_BASE   = 0,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] addend,
  output logic              busy,
  output logic              valid,
  output logic [ADDR_W-1:0] raddr_0,
  input  logic [DATA_W-1:0] rdata_0,
  output logic [ADDR_W-1:0] waddr_0,
  output logic [DATA_W-1:0] wdata_0,
  output logic              wen_0
);

  localparam int CW = (TRIP_COUNT < 1) ? 1 : $clog2(TRIP_COUNT + 1);
  localparam logic [ADDR_W-1:0] SRC0 = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST0 = ADDR_W'(DST_BASE);

  generate
    if (TRIP_COUNT < 1) begin : g_bad_trip
      $error("loop_add_const_pipe: TRIP_COUNT must be >= 1");
    end
    if (RD_LAT < 0 || RD_LAT > 2) begin : g_bad_lat
      $error("loop_add_const_pipe: RD_LAT must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_icnt;
  logic [CW-1:0]     r_wcnt;
  logic [RD_LAT:0]   r_vld;
  logic [DATA_W-1:0] r_addend;
  logic [DATA_W-1:0] w_res;
  logic              w_accept;
  logic              w_issue;
  logic              w_last_issue;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue  = w_accept || (r_state == S_RUN);

  // Accept edge issues element 0; a single-trip run is done issuing there.
  assign w_last_issue =
    (w_accept && TRIP_COUNT == 1) ||
    (r_state == S_RUN && r_icnt == CW'(TRIP_COUNT - 1));

`ifdef LOOP_ADD_SAT_EN
  logic [DATA_W:0] w_sum;
  assign w_sum = {1'b0, rdata_0} + {1'b0, r_addend};
  assign w_res = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
  assign w_res = rdata_0 + r_addend;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = w_last_issue ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (wen_0 && r_wcnt == CW'(TRIP_COUNT)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_0  <= '0;
      waddr_0  <= '0;
      wdata_0  <= '0;
      wen_0    <= 1'b0;
      r_vld    <= '0;
      r_icnt   <= '0;
      r_wcnt   <= '0;
      r_addend <= '0;
    end else begin
      wen_0 <= 1'b0;
      if (w_accept) begin
        r_addend <= addend;
        raddr_0  <= SRC0;
        r_icnt   <= CW'(1);
        r_wcnt   <= '0;
      end else if (r_state == S_RUN) begin
        raddr_0 <= raddr_0 + ADDR_W'(1);
        r_icnt  <= r_icnt + CW'(1);
      end
      // r_vld[j]: the address issued j edges ago is in flight
      r_vld[0] <= w_issue;
      for (int j = RD_LAT; j > 0; j--) begin
        r_vld[j] <= r_vld[j-1];
      end
      if (r_vld[RD_LAT]) begin
        wen_0   <= 1'b1;
        wdata_0 <= w_res;
        waddr_0 <= (r_wcnt == '0) ? DST0 : waddr_0 + ADDR_W'(1);
        r_wcnt  <= r_wcnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_loop_add_const_pipe.sv
// Directed bench for loop_add_const_pipe with a timeline model and RAM2 memories.
// A second instance covers address wrap with different base/trip parameters.
module tb_loop_add_const_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int T  = 6;
  localparam int SRC = 10;
  localparam int DST = 0;
  localparam int RL  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, start_b;
  logic [DW-1:0] addend, addend_b;
  logic          busy, valid, wen;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] rdata, wdata;
  logic          busy_b, valid_b, wen_b;
  logic [AW-1:0] raddr_b, waddr_b;
  logic [DW-1:0] rdata_b, wdata_b;

  logic [DW-1:0] mem   [32];
  logic [DW-1:0] mem_b [32];

  loop_add_const_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .TRIP_COUNT(T),
    .SRC_BASE(SRC), .DST_BASE(DST), .RD_LAT(RL)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .addend(addend),
    .busy(busy), .valid(valid),
    .raddr_0(raddr), .rdata_0(rdata),
    .waddr_0(waddr), .wdata_0(wdata), .wen_0(wen)
  );

  loop_add_const_pipe #(
    .DATA_W(DW), .ADDR_W(AW), .TRIP_COUNT(4),
    .SRC_BASE(30), .DST_BASE(2), .RD_LAT(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .addend(addend_b),
    .busy(busy_b), .valid(valid_b),
    .raddr_0(raddr_b), .rdata_0(rdata_b),
    .waddr_0(waddr_b), .wdata_0(wdata_b), .wen_0(wen_b)
  );

  // RAM2 memories, one-edge read latency
  always @(posedge clk) begin
    rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
  end

  always @(posedge clk) begin
    rdata_b <= mem_b[raddr_b];
    if (wen_b) mem_b[waddr_b] <= wdata_b;
  end

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int e     = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fsum(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef LOOP_ADD_SAT_EN
    if (s[DW]) return '1;
`endif
    return s[DW-1:0];
  endfunction

  // Timeline model: m_n counts edges since the accept edge E0
  int            m_n = -1;
  logic          m_busy = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_wen = 1'b0;
  logic [AW-1:0] m_raddr = '0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_add = '0;
  logic [DW-1:0] m_src [T];

  always @(posedge clk) begin
    if (rst) begin
      m_n = -1;
      m_valid = 1'b0;
      m_raddr = '0;
      m_waddr = '0;
    end else if (start && !m_busy) begin
      m_n = 0;
      m_add = addend;
      m_valid = 1'b0;
      for (int k = 0; k < T; k++) m_src[k] = mem[AW'(SRC + k)];
    end else if (m_n >= 0 && m_n < 1000) begin
      m_n++;
    end
    m_busy = (m_n >= 0) && (m_n <= T + RL);
    if (m_n == T + RL + 1) m_valid = 1'b1;
    m_wen = (m_n >= RL + 1) && (m_n <= T + RL);
    if (m_n >= 0 && m_n < T) m_raddr = AW'(SRC + m_n);
    if (m_wen) begin
      m_waddr = AW'(DST + m_n - RL - 1);
      m_wdata = fsum(m_src[m_n-RL-1], m_add);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("valid", valid, m_valid);
      chk("wen", wen, m_wen);
      chk("raddr", raddr, m_raddr);
      chk("waddr", waddr, m_waddr);
      if (m_wen) chk("wdata", wdata, m_wdata);
    end
    if (wen === 1'b1) n_wr++;
  end

  task automatic run_a(input logic [DW-1:0] v);
    @(posedge clk);
    #1 start = 1'b1;
    addend = v;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
  endtask

  task automatic adv(input int k);
    repeat (k - e) @(posedge clk);
    @(negedge clk);
    e = k;
  endtask

  task automatic check_mem(input string name);
    for (int k = 0; k < T; k++)
      chk(name, mem[AW'(DST + k)], fsum(m_src[k], m_add));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_b = 1'b0;
    addend = '0;
    addend_b = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_wen", wen, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_b_busy", busy_b, 0);
    mem[10] = 10;
    mem[11] = 5;
    mem[12] = 100;
    mem[13] = 200;
    mem[14] = 300;
    mem[15] = 400;
    @(posedge clk);
    #1 rst = 1'b0;

    // basic run
    run_a(4);
    adv(1);
    chk("t1_wen_e1", wen, 0);
    adv(2);
    chk("t1_wen_e2", wen, 1);
    chk("t1_wdata_e2", wdata, 14);
    chk("t1_waddr_e2", waddr, 0);
    adv(7);
    chk("t1_valid_e7", valid, 0);
    adv(8);
    chk("t1_valid_e8", valid, 1);
    chk("t1_mem0", mem[0], 14);
    chk("t1_mem1", mem[1], 9);
    check_mem("t1_mem");

    // hold through idle, then a start while busy is ignored
    repeat (20) @(negedge clk);
    chk("t2_valid_hold", valid, 1);
    chk("t2_mem0_hold", mem[0], 14);
    chk("t2_mem1_hold", mem[1], 9);
    n_wr = 0;
    run_a(7);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 2;
    adv(8);
    repeat (10) @(negedge clk);
    chk("t2_nwrites", n_wr, T);
    chk("t2_valid", valid, 1);
    chk("t2_mem0", mem[0], 17);
    chk("t2_mem1", mem[1], 12);
    check_mem("t2_mem");

    // re-run with a new addend
    run_a(1);
    @(negedge clk);
    chk("t3_valid_drop", valid, 0);
    chk("t3_busy", busy, 1);
    adv(8);
    chk("t3_valid", valid, 1);
    chk("t3_mem0", mem[0], 11);
    chk("t3_mem1", mem[1], 6);
    check_mem("t3_mem");

    // reset at E3 of a run
    run_a(2);
    adv(2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_wr = 0;
    @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_valid", valid, 0);
    chk("t4_wen", wen, 0);
    repeat (15) @(negedge clk);
    chk("t4_nwrites", n_wr, 0);
    chk("t4_mem1", mem[1], 6);
    chk("t4_mem2", mem[2], 101);
    run_a(3);
    adv(8);
    chk("t4_rerun_valid", valid, 1);
    chk("t4_rerun_mem0", mem[0], 13);
    chk("t4_rerun_mem1", mem[1], 8);
    check_mem("t4_mem");

    // overflow
    mem[10] = 32'hFFFF_FFFE;
    run_a(4);
    adv(8);
`ifdef LOOP_ADD_SAT_EN
    chk("t6_mem0", mem[0], 32'hFFFF_FFFF);
`else
    chk("t6_mem0", mem[0], 2);
`endif
    check_mem("t6_mem");

    // address wrap on the second instance
    mem_b[30] = 1;
    mem_b[31] = 2;
    mem_b[0]  = 3;
    mem_b[1]  = 4;
    @(posedge clk);
    #1 start_b = 1'b1;
    addend_b = 4;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int i = 0; i < 40 && valid_b !== 1'b1; i++) @(negedge clk);
    chk("t5_done", valid_b, 1);
    chk("t5_busy", busy_b, 0);
    chk("t5_mem2", mem_b[2], 5);
    chk("t5_mem3", mem_b[3], 6);
    chk("t5_mem4", mem_b[4], 7);
    chk("t5_mem5", mem_b[5], 8);
    chk("t5_src30", mem_b[30], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
